// File: rtl/div_seq.sv
// Iterative restoring radix-2 divider answering the EX-stage divide handshake.
// Produces {remainder, quotient}; signed mode divides magnitudes and fixes the signs at the end.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;

    // The shifted partial remainder needs WIDTH+1 bits: an unsigned divisor can exceed 2^(WIDTH-1).
    always_comb begin
        w_trial   = {r_rem, r_dvd[WIDTH-1]};
        w_ge      = (w_trial >= {1'b0, r_dvs});
        w_rem_sub = w_trial[WIDTH-1:0] - r_dvs;
        w_abs_a   = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + LP_ONE) : opdata1_i;
        w_abs_b   = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + LP_ONE) : opdata2_i;
        w_q_fin   = r_neg_q ? (~r_dvd + LP_ONE) : r_dvd;
        w_r_fin   = r_neg_r ? (~r_rem + LP_ONE) : r_rem;
    end

    // r_dvd shifts the dividend out at the top while quotient bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FREE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (r_state)
                S_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_dvs   <= w_abs_b;
                        if (opdata2_i == '0) begin
                            r_state <= S_BYZERO;
                            r_dvd   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            r_state <= S_ON;
                            r_dvd   <= w_abs_a;
                            r_neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            r_neg_r <= signed_div_i && opdata1_i[WIDTH-1];
                        end
                    end
                end
                S_BYZERO: begin
                    r_state <= annul_i ? S_FREE : S_END;
                end
                S_ON: begin
                    if (annul_i) begin
                        r_state <= S_FREE;
                    end else begin
                        r_rem <= w_ge ? w_rem_sub : w_trial[WIDTH-1:0];
                        r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LP_LAST) begin
                            r_state <= S_END;
                        end
                    end
                end
                S_END: begin
                    if (annul_i) begin
                        r_state  <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else if (!ready_o) begin
                        ready_o  <= 1'b1;
                        result_o <= {w_r_fin, w_q_fin};
                    end else if (!start_i) begin
                        r_state  <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: begin
                    r_state  <= S_FREE;
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: driver issues divides and pushes expected results;
// a negedge monitor pops and compares whenever ready_o rises.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        mon_prev = 1'b0;

    div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon_prev = 1'b0;
        end else begin
            if (ready_o && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got result %h expected no result", result_o);
                end else begin
                    check("result", result_o, exp_q.pop_front());
                end
            end
            if (!ready_o) check("idle_result_zero", result_o, 64'd0);
            mon_prev = ready_o;
        end
    end

    // Operands are scrambled right after acceptance; the result must reflect the latched ones.
    task automatic do_div(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit hold);
        int lat;
        lat = 0;
        exp_q.push_back(exp);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_i = 1'b0;
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
        while (!ready_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
        if (hold) begin
            repeat (3) begin
                @(posedge clk);
                #1;
                check({name, "_ready_hold"}, 64'(ready_o), 64'd1);
                check({name, "_result_hold"}, result_o, exp);
            end
            @(negedge clk);
            start_i = 1'b0;
            @(posedge clk);
            #1;
            check({name, "_ready_drop"}, 64'(ready_o), 64'd0);
            check({name, "_result_drop"}, result_o, 64'd0);
        end else begin
            @(posedge clk);
            #1;
            check({name, "_ready_pulse"}, 64'(ready_o), 64'd0);
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check(name, 64'(ready_o), 64'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_div("u_7_2",        1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 1'b1);
        do_div("s_m7_2",       1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        do_div("s_7_m2",       1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b1);
        do_div("s_min_m1",     1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
        do_div("u_max_1",      1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 1'b1);
        do_div("u_max_min",    1'b0, 32'hFFFFFFFF, 32'h80000000, 64'h7FFFFFFF_00000001, 1'b0);
        do_div("s_min_m7",     1'b1, 32'h80000000, 32'hFFFFFFF9, 64'hFFFFFFFE_12492492, 1'b1);
        do_div("s_zero_div",   1'b1, 32'd1234,     32'd0,        64'd0,                 1'b1);
        do_div("u_zero_div",   1'b0, 32'hFFFFFFFF, 32'd0,        64'd0,                 1'b0);

        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd12345;
        opdata2_i    = 32'd11;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_result", result_o, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        expect_quiet("annul_no_ready", 40);
        do_div("u_100_7",      1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b1);

        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd555;
        opdata2_i    = 32'd5;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_ready", 64'(ready_o), 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        expect_quiet("rst_no_ready", 40);
        do_div("u_1000_3",     1'b0, 32'd1000,     32'd3,        64'h00000001_0000014D, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
